// File: rtl/gb_ext_bridge_pkg.sv
// Shared definitions for the ghostbus external bridge: default localbus
// widths and the channel-index width helper used for window decode.
package gb_ext_bridge_pkg;

    localparam int GB_AW = 24;
    localparam int GB_DW = 32;

    // Number of address bits needed to select one of nch channels (at least 1).
    function automatic int gb_chw(input int nch);
        int w;
        w = 0;
        while ((1 << w) < nch) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/gb_ext_bridge_read_pipe.sv
// Fixed-depth shift register with asynchronous clear. Every stage is
// exposed so the parent can tap the tag at the cycle it needs it.
module gb_ext_bridge_read_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [WIDTH-1:0]         d_i,
    output logic [DEPTH*WIDTH-1:0]   stages_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Shift one stage per clock; reset flushes every in-flight entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign stages_o = stage_q;

endmodule

// File: rtl/gb_ext_bridge.sv
// Bridge from the 32-bit ghostbus host localbus to NCH narrow external
// peripherals: window decode, per-channel level/edge read strobes,
// registered external strobes and a read-return pipeline that lines the
// returned data up with the host read delay.
module gb_ext_bridge
    import gb_ext_bridge_pkg::*;
#(
    parameter int              AW         = GB_AW,
    parameter int              DW         = GB_DW,
    parameter int              NCH        = 2,
    parameter int              EXT_AW     = 11,
    parameter int              EXT_DW     = 8,
    parameter logic [AW-1:0]   BASE       = 24'h010000,
    parameter int              RD_LAT     = 1,
    parameter int              READ_DELAY = 3,
    parameter logic [NCH-1:0]  EDGE_MASK  = 2'b01
) (
    input  logic                  lb_clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         lb_addr,
    input  logic                  lb_write,
    input  logic                  lb_read,
    input  logic [DW-1:0]         lb_wdata,
    output logic [DW-1:0]         lb_rdata,
    output logic                  lb_rvalid,
    output logic [EXT_AW-1:0]     ext_addr,
    output logic [EXT_DW-1:0]     ext_wdata,
    output logic [NCH-1:0]        ext_wen,
    output logic [NCH-1:0]        ext_ren,
    input  logic [NCH*EXT_DW-1:0] ext_rdata,
    output logic                  hit
);

    localparam int CHW    = gb_chw(NCH);
    localparam int WLO    = EXT_AW + CHW;
    localparam int TW     = CHW + 2;
    localparam int TDEPTH = READ_DELAY - 1;
    localparam int DDEPTH = READ_DELAY - 2 - RD_LAT;

    // Parameter sanity: the host must wait long enough for the peripheral,
    // the external word must fit the host word, and NCH must fit CHW bits.
    if (READ_DELAY < RD_LAT + 2) begin : g_err_delay
        $error("gb_ext_bridge: READ_DELAY must be >= RD_LAT+2");
    end
    if (EXT_DW > DW) begin : g_err_width
        $error("gb_ext_bridge: EXT_DW must not exceed DW");
    end
    if (NCH > (1 << CHW)) begin : g_err_nch
        $error("gb_ext_bridge: NCH does not fit the channel index");
    end

    // ------------------------------------------------------------------
    // Decode and strobe generation
    // ------------------------------------------------------------------
    logic              dec_inwin_s;
    logic [CHW-1:0]    dec_ch_s;
    logic              same_run_s;
    logic              strobe_s;

    logic              lb_read_q;
    logic [AW-1:0]     lb_addr_q;

    logic [NCH-1:0]    ext_wen_d,   ext_wen_q;
    logic [NCH-1:0]    ext_ren_d,   ext_ren_q;
    logic [EXT_AW-1:0] ext_addr_d,  ext_addr_q;
    logic [EXT_DW-1:0] ext_wdata_d, ext_wdata_q;
    logic              hit_d,       hit_q;

    // Window decode: upper bits match the base and the channel index exists.
    always_comb begin
        dec_ch_s = lb_addr[WLO-1:EXT_AW];
        if ((lb_addr[AW-1:WLO] == BASE[AW-1:WLO]) &&
            ({1'b0, dec_ch_s} < (CHW+1)'(NCH))) begin
            dec_inwin_s = 1'b1;
        end else begin
            dec_inwin_s = 1'b0;
        end
    end

    // Next-state of the external strobes, shared address/data and hit flag.
    always_comb begin
        same_run_s  = lb_read_q && (lb_addr == lb_addr_q);
        strobe_s    = lb_read | lb_write;
        ext_wen_d   = '0;
        ext_ren_d   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (dec_inwin_s && (dec_ch_s == CHW'(i))) begin
                ext_wen_d[i] = lb_write;
                // An edge channel only sees the first cycle of a read run to
                // one address; a new address starts a new run.
                if (EDGE_MASK[i]) begin
                    ext_ren_d[i] = lb_read && !same_run_s;
                end else begin
                    ext_ren_d[i] = lb_read;
                end
            end else begin
                ext_wen_d[i] = 1'b0;
                ext_ren_d[i] = 1'b0;
            end
        end
        if (strobe_s) begin
            ext_addr_d  = lb_addr[EXT_AW-1:0];
            ext_wdata_d = lb_wdata[EXT_DW-1:0];
            hit_d       = dec_inwin_s;
        end else begin
            ext_addr_d  = ext_addr_q;
            ext_wdata_d = ext_wdata_q;
            hit_d       = hit_q;
        end
    end

    // Register the external-side outputs and the previous-cycle read/address.
    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_read_q   <= 1'b0;
            lb_addr_q   <= '0;
            ext_wen_q   <= '0;
            ext_ren_q   <= '0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            hit_q       <= 1'b0;
        end else begin
            lb_read_q   <= lb_read;
            lb_addr_q   <= lb_addr;
            ext_wen_q   <= ext_wen_d;
            ext_ren_q   <= ext_ren_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            hit_q       <= hit_d;
        end
    end

    assign ext_wen   = ext_wen_q;
    assign ext_ren   = ext_ren_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign hit       = hit_q;

    // ------------------------------------------------------------------
    // Read-return pipeline
    // Stage k of the tag pipe holds the read issued k+1 cycles earlier.
    // ------------------------------------------------------------------
    logic [TW-1:0]        tag_in_s;
    logic [TDEPTH*TW-1:0] tag_stages_s;
    logic [TW-1:0]        tap_s;
    logic [TW-1:0]        fin_s;
    logic [NCH-1:0]       cap_sel_s;
    logic [EXT_DW-1:0]    cap_data_s;
    logic [EXT_DW-1:0]    ret_data_s;
    logic                 lb_rvalid_q;
    logic [DW-1:0]        lb_rdata_q;
    logic                 unused_s;

    assign tag_in_s = {lb_read, lb_read & dec_inwin_s, dec_ch_s};

    gb_ext_bridge_read_pipe #(
        .DEPTH (TDEPTH),
        .WIDTH (TW)
    ) u_tag_pipe (
        .clk_i    (lb_clk),
        .rst_ni   (rst_n),
        .d_i      (tag_in_s),
        .stages_o (tag_stages_s)
    );

    assign tap_s = tag_stages_s[RD_LAT*TW +: TW];
    assign fin_s = tag_stages_s[(TDEPTH-1)*TW +: TW];

    // Pick the addressed channel's read data while it is valid; zero otherwise.
    always_comb begin
        cap_data_s = '0;
        for (int i = 0; i < NCH; i++) begin
            cap_sel_s[i] = tap_s[TW-1] && tap_s[CHW] && (tap_s[CHW-1:0] == CHW'(i));
            cap_data_s   = cap_data_s | ({EXT_DW{cap_sel_s[i]}} & ext_rdata[i*EXT_DW +: EXT_DW]);
        end
    end

    if (DDEPTH > 0) begin : g_data_dly
        logic [DDEPTH*EXT_DW-1:0] data_stages_s;

        gb_ext_bridge_read_pipe #(
            .DEPTH (DDEPTH),
            .WIDTH (EXT_DW)
        ) u_data_pipe (
            .clk_i    (lb_clk),
            .rst_ni   (rst_n),
            .d_i      (cap_data_s),
            .stages_o (data_stages_s)
        );

        assign ret_data_s = data_stages_s[(DDEPTH-1)*EXT_DW +: EXT_DW];
    end else begin : g_data_direct
        assign ret_data_s = cap_data_s;
    end

    // Present one rvalid per host read; data holds between returns.
    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_rvalid_q <= 1'b0;
            lb_rdata_q  <= '0;
        end else if (fin_s[TW-1]) begin
            lb_rvalid_q <= 1'b1;
            lb_rdata_q  <= DW'(ret_data_s);
        end else begin
            lb_rvalid_q <= 1'b0;
        end
    end

    assign lb_rvalid = lb_rvalid_q;
    assign lb_rdata  = lb_rdata_q;

    // Upper write-data bits and the non-tapped tag fields are intentionally dropped.
    assign unused_s = ^{lb_wdata, tag_stages_s};

endmodule

// File: tb/tb_gb_ext_bridge.sv
// Self-checking bench for gb_ext_bridge: directed scenarios plus a
// randomized run against a cycle-indexed reference model.
module tb_gb_ext_bridge;

    localparam int          RD_LAT     = 1;
    localparam int          READ_DELAY = 3;
    localparam logic [1:0]  EDGE       = 2'b01;
    localparam int          N_RAND     = 400;
    localparam int          OFF        = 8;
    localparam int          NA         = N_RAND + OFF + 8;

    logic        lb_clk = 1'b0;
    logic        rst_n;
    logic [23:0] lb_addr;
    logic        lb_write;
    logic        lb_read;
    logic [31:0] lb_wdata;
    logic [31:0] lb_rdata;
    logic        lb_rvalid;
    logic [10:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [1:0]  ext_wen;
    logic [1:0]  ext_ren;
    logic [15:0] ext_rdata;
    logic        hit;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 lb_clk = ~lb_clk;

    gb_ext_bridge #(
        .AW(24), .DW(32), .NCH(2), .EXT_AW(11), .EXT_DW(8),
        .BASE(24'h010000), .RD_LAT(RD_LAT), .READ_DELAY(READ_DELAY), .EDGE_MASK(EDGE)
    ) dut (
        .lb_clk(lb_clk), .rst_n(rst_n), .lb_addr(lb_addr), .lb_write(lb_write),
        .lb_read(lb_read), .lb_wdata(lb_wdata), .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_wen(ext_wen), .ext_ren(ext_ren),
        .ext_rdata(ext_rdata), .hit(hit)
    );

    task automatic step();
        @(posedge lb_clk);
        #1;
    endtask

    task automatic idle(input int n);
        lb_read  = 1'b0;
        lb_write = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Reference decode: two 2048-word windows starting at 0x10000.
    function automatic bit m_inwin(input logic [23:0] a);
        return (a >= 24'h010000) && (a < 24'h011000);
    endfunction

    function automatic int m_ch(input logic [23:0] a);
        return int'((a - 24'h010000) / 24'd2048);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            lb_read   = 1'($urandom_range(0, 1));
            lb_write  = 1'($urandom_range(0, 1));
            lb_addr   = 24'h010000 | 24'($urandom_range(0, 4095));
            lb_wdata  = $urandom;
            ext_rdata = 16'($urandom);
            step();
            n_tests++;
            if ({lb_rdata, lb_rvalid, ext_addr, ext_wdata, ext_wen, ext_ren, hit} !== 56'd0)
                begin n_fail++; $display("FAIL reset_hold: outputs %h required 0",
                    {lb_rdata, lb_rvalid, ext_addr, ext_wdata, ext_wen, ext_ren, hit}); end
        end
        lb_read  = 1'b0;
        lb_write = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if ({ext_wen, ext_ren, lb_rvalid, hit} !== 6'd0) begin
                n_fail++;
                $display("FAIL reset_release: strobes %b required 0", {ext_wen, ext_ren, lb_rvalid, hit});
            end
        end
    endtask

    task automatic test_write();
        lb_addr  = 24'h010005;
        lb_wdata = 32'hA5A5A5A5;
        lb_write = 1'b1;
        step();
        lb_write = 1'b0;
        n_tests++;
        if ({ext_wen, ext_ren, ext_addr, ext_wdata, hit} !== {2'b01, 2'b00, 11'h005, 8'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL write_ch0: wen=%b ren=%b addr=%h wd=%h hit=%b required 01 00 005 a5 1",
                     ext_wen, ext_ren, ext_addr, ext_wdata, hit);
        end
        step();
        n_tests++;
        if (ext_wen !== 2'b00) begin n_fail++; $display("FAIL write_single: wen=%b required 00", ext_wen); end
        idle(3);
    endtask

    task automatic test_read_level();
        ext_rdata = 16'h3C77;
        lb_addr   = 24'h010803;
        lb_read   = 1'b1;
        step();
        lb_read = 1'b0;
        n_tests++;
        if ({ext_ren, ext_addr, lb_rvalid, hit} !== {2'b10, 11'h003, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL read_ren: ren=%b addr=%h rv=%b hit=%b required 10 003 0 1", ext_ren, ext_addr, lb_rvalid, hit);
        end
        step();
        n_tests++;
        if ({ext_ren, lb_rvalid} !== 3'b000) begin
            n_fail++; $display("FAIL read_early: ren=%b rv=%b required 00 0", ext_ren, lb_rvalid);
        end
        step();
        n_tests++;
        if ({lb_rvalid, lb_rdata} !== {1'b1, 32'h0000003C}) begin
            n_fail++; $display("FAIL read_return: rv=%b rdata=%h required 1 0000003c", lb_rvalid, lb_rdata);
        end
        step();
        n_tests++;
        if ({lb_rvalid, lb_rdata} !== {1'b0, 32'h0000003C}) begin
            n_fail++; $display("FAIL read_hold: rv=%b rdata=%h required 0 0000003c", lb_rvalid, lb_rdata);
        end
        idle(2);
    endtask

    task automatic test_edge_hold();
        int n_ren0, n_ren1, n_rv;
        int exp_ren0, exp_ren1;
        logic [31:0] exp_d;
        ext_rdata = 16'h335A;
        // s0: ch0 edge held 4 cycles; s1: ch1 level held 3; s2: ch0 edge, address changes mid-run
        for (int s = 0; s < 3; s++) begin
            n_ren0 = 0; n_ren1 = 0; n_rv = 0;
            for (int i = 0; i < 10; i++) begin
                case (s)
                    0:       begin lb_addr = 24'h010010; lb_read = (i < 4); end
                    1:       begin lb_addr = 24'h010820; lb_read = (i < 3); end
                    default: begin lb_addr = (i < 2) ? 24'h010010 : 24'h010011; lb_read = (i < 4); end
                endcase
                exp_d = (s == 1) ? 32'h33 : 32'h5A;
                step();
                n_ren0 += int'(ext_ren[0]);
                n_ren1 += int'(ext_ren[1]);
                if (lb_rvalid) begin
                    n_rv++;
                    n_tests++;
                    if (lb_rdata !== exp_d) begin
                        n_fail++; $display("FAIL edge_data s%0d: rdata=%h required %h", s, lb_rdata, exp_d);
                    end
                end
            end
            exp_ren0 = (s == 0) ? 1 : ((s == 2) ? 2 : 0);
            exp_ren1 = (s == 1) ? 3 : 0;
            n_tests++;
            if (n_ren0 != exp_ren0 || n_ren1 != exp_ren1) begin
                n_fail++;
                $display("FAIL edge_ren s%0d: ren0=%0d ren1=%0d required %0d %0d", s, n_ren0, n_ren1, exp_ren0, exp_ren1);
            end
            n_tests++;
            if (n_rv != ((s == 1) ? 3 : 4)) begin
                n_fail++; $display("FAIL edge_rvalid s%0d: count=%0d required %0d", s, n_rv, (s == 1) ? 3 : 4);
            end
        end
    endtask

    task automatic test_outside();
        lb_addr = 24'h020000;
        lb_read = 1'b1;
        step();
        lb_read = 1'b0;
        n_tests++;
        if ({ext_ren, hit} !== 3'b000) begin
            n_fail++; $display("FAIL out_ren: ren=%b hit=%b required 00 0", ext_ren, hit);
        end
        step();
        step();
        n_tests++;
        if ({lb_rvalid, lb_rdata} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL out_return: rv=%b rdata=%h required 1 00000000", lb_rvalid, lb_rdata);
        end
        lb_addr  = 24'h00FFFF;
        lb_write = 1'b1;
        lb_read  = 1'b1;
        step();
        n_tests++;
        if ({ext_wen, ext_ren, hit} !== 5'b00000) begin
            n_fail++; $display("FAIL below_base: wen=%b ren=%b hit=%b required 00 00 0", ext_wen, ext_ren, hit);
        end
        lb_addr = 24'h010FFF;
        step();
        n_tests++;
        if ({ext_wen, ext_ren, ext_addr, hit} !== {2'b10, 2'b10, 11'h7FF, 1'b1}) begin
            n_fail++;
            $display("FAIL window_top: wen=%b ren=%b addr=%h hit=%b required 10 10 7ff 1", ext_wen, ext_ren, ext_addr, hit);
        end
        idle(4);
    endtask

    task automatic test_random();
        bit          rd_a [NA];
        bit          wr_a [NA];
        logic [23:0] ad_a [NA];
        logic [15:0] xd_a [NA];
        logic [7:0]  wd_a [NA];
        logic [1:0]  exp_wen, exp_ren;
        logic [31:0] exp_rdata;
        logic        exp_hit, exp_rv;
        logic [10:0] exp_addr;
        logic [7:0]  exp_wd;
        bit          rdata_known, side_known;
        int          c, t, ch, r;
        logic [23:0] ad;
        rdata_known = 1'b0;
        side_known  = 1'b0;
        exp_rdata = '0; exp_hit = 1'b0; exp_addr = '0; exp_wd = '0;
        for (int i = 0; i < NA; i++) begin
            rd_a[i] = 1'b0; wr_a[i] = 1'b0; ad_a[i] = '0; xd_a[i] = '0; wd_a[i] = '0;
        end
        for (int k = 0; k < N_RAND + READ_DELAY + 1; k++) begin
            c = k + OFF;
            if (k < N_RAND) begin
                r = int'($urandom_range(0, 9));
                if (r < 6)      ad = 24'h010000 + 24'($urandom_range(0, 1) * 2048) + 24'($urandom_range(0, 3));
                else if (r < 8) ad = 24'h010000 + 24'($urandom_range(0, 4095));
                else            ad = 24'($urandom);
                if ($urandom_range(0, 2) == 0) ad = ad_a[c-1];
                rd_a[c] = ($urandom_range(0, 9) < 6);
                wr_a[c] = ($urandom_range(0, 9) < 3);
                ad_a[c] = ad;
            end
            lb_addr   = ad_a[c];
            lb_read   = rd_a[c];
            lb_write  = wr_a[c];
            lb_wdata  = $urandom;
            ext_rdata = 16'($urandom);
            xd_a[c]   = ext_rdata;
            wd_a[c]   = lb_wdata[7:0];
            step();
            exp_wen = 2'b00;
            exp_ren = 2'b00;
            if (m_inwin(ad_a[c])) begin
                ch = m_ch(ad_a[c]);
                exp_wen[ch] = wr_a[c];
                if (EDGE[ch]) exp_ren[ch] = rd_a[c] && !(rd_a[c-1] && ad_a[c-1] == ad_a[c]);
                else          exp_ren[ch] = rd_a[c];
            end
            if (rd_a[c] || wr_a[c]) begin
                exp_hit    = m_inwin(ad_a[c]);
                exp_addr   = 11'(ad_a[c] % 24'd2048);
                exp_wd     = wd_a[c];
                side_known = 1'b1;
            end
            t = c + 1 - READ_DELAY;
            exp_rv = rd_a[t];
            if (exp_rv) begin
                if (m_inwin(ad_a[t])) exp_rdata = 32'((xd_a[t + 1 + RD_LAT] >> (8 * m_ch(ad_a[t]))) & 16'h00FF);
                else                  exp_rdata = 32'h0;
                rdata_known = 1'b1;
            end
            n_tests++;
            if ({ext_wen, ext_ren, lb_rvalid} !== {exp_wen, exp_ren, exp_rv}) begin
                n_fail++;
                $display("FAIL rand_strobe k=%0d: wen/ren/rv=%b required %b", k, {ext_wen, ext_ren, lb_rvalid}, {exp_wen, exp_ren, exp_rv});
            end
            if (rdata_known) begin
                n_tests++;
                if (lb_rdata !== exp_rdata) begin
                    n_fail++; $display("FAIL rand_rdata k=%0d: rdata=%h required %h", k, lb_rdata, exp_rdata);
                end
            end
            if (side_known) begin
                n_tests++;
                if ({ext_addr, ext_wdata, hit} !== {exp_addr, exp_wd, exp_hit}) begin
                    n_fail++;
                    $display("FAIL rand_side k=%0d: addr/wd/hit=%h required %h", k, {ext_addr, ext_wdata, hit}, {exp_addr, exp_wd, exp_hit});
                end
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] q [$];
        int got, late;
        got  = 0;
        late = 0;
        ext_rdata = 16'h2211;
        for (int k = 0; k < 6; k++) begin
            lb_addr = (k % 2 == 0) ? 24'h010000 + 24'(k) : 24'h010800 + 24'(k);
            lb_read = 1'b1;
            q.push_back((k % 2 == 0) ? 32'h11 : 32'h22);
            step();
            n_tests++;
            if (ext_ren !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL alt_ren k=%0d: ren=%b required %b", k, ext_ren, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (lb_rvalid) begin
                got++;
                n_tests++;
                if (q.size() == 0 || lb_rdata !== q[0]) begin
                    n_fail++; $display("FAIL alt_order k=%0d: rdata=%h required %h", k, lb_rdata, (q.size() == 0) ? 32'h0 : q[0]);
                end
                if (q.size() > 0) void'(q.pop_front());
            end
        end
        n_tests++;
        if (got != 4) begin n_fail++; $display("FAIL alt_count: rvalids=%0d required 4", got); end
        lb_read = 1'b0;
        rst_n   = 1'b0;
        #1;
        n_tests++;
        if ({lb_rdata, lb_rvalid, ext_wen, ext_ren, hit} !== 38'd0) begin
            n_fail++; $display("FAIL mid_reset_clear: outputs %h required 0", {lb_rdata, lb_rvalid, ext_wen, ext_ren, hit});
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            late += int'(lb_rvalid) + int'(ext_ren[0]) + int'(ext_ren[1]);
        end
        n_tests++;
        if (late != 0) begin n_fail++; $display("FAIL mid_reset_late: late strobes=%0d required 0", late); end
    endtask

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        lb_addr   = '0;
        lb_read   = 1'b0;
        lb_write  = 1'b0;
        lb_wdata  = '0;
        ext_rdata = '0;
        test_reset();
        test_write();
        test_read_level();
        test_edge_hold();
        test_outside();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
